prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 122 ++++++++++++
 tb/tb_prog_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_counter: programmable up/down counter with IDLE/RUN/DONE control FSM. |
// | Optional prescaler enabled by macro PROG_COUNTER_PRESCALE_EN.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module prog_counter #(
  parameter int WIDTH = 8
`ifdef PROG_COUNTER_PRESCALE_EN
  ,parameter int PRESCALE_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             saturate,
  input  logic [WIDTH-1:0] limit,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             tick;
  logic             step;
  logic             held;
  logic             arrival;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step_val;

  // Next value if a step is taken; the saturated hold case never counts as arrival.
  always_comb begin
    term = dir ? limit : '0;
    step = (state == RUN) && tick && !load;
    held = (count == term) && saturate;
    if (count != term)
      step_val = dir ? count + WIDTH'(1) : count - WIDTH'(1);
    else if (!saturate)
      step_val = dir ? '0 : limit;
    else
      step_val = count;
    arrival = step && !held && (step_val == term);
  end

  // stop wins over start and over a oneshot arrival.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!stop && start) state_nxt = RUN;
      RUN: begin
        if (stop)
          state_nxt = IDLE;
        else if (arrival && oneshot)
          state_nxt = DONE;
      end
      DONE: begin
        if (stop)
          state_nxt = IDLE;
        else if (start)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      tc    <= arrival;
      if (load)
        count <= load_val;
      else if (step)
        count <= step_val;
    end
  end

`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  enter_done;

  assign enter_done = (state == RUN) && (state_nxt == DONE);
  // >= keeps the prescaler from running a full wrap if prescale is lowered mid-count.
  assign tick       = enable && (pre_cnt >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_cnt <= '0;
    else if (start || stop || load || enter_done)
      pre_cnt <= '0;
    else if ((state == RUN) && enable)
      pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
  end
`else
  assign tick = enable;
`endif

  assign match = (count == limit);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_counter: directed scenarios plus randomized run against a model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_prog_counter;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         start;
  logic         stop;
  logic         load;
  logic [W-1:0] load_val;
  logic         dir;
  logic         oneshot;
  logic         saturate;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         tc;
  logic         match;
  logic         busy;
  logic         done;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [3:0]   prescale;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: count as plain integer, FSM as 0=idle 1=run 2=done.
  int m_count;
  int m_state;
  int m_pre;
  bit m_tc;

  prog_counter #(
    .WIDTH(W)
`ifdef PROG_COUNTER_PRESCALE_EN
    ,.PRESCALE_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .start(start),
    .stop(stop),
    .load(load),
    .load_val(load_val),
    .dir(dir),
    .oneshot(oneshot),
    .saturate(saturate),
    .limit(limit),
`ifdef PROG_COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count),
    .tc(tc),
    .match(match),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_count = 0;
    m_state = 0;
    m_pre   = 0;
    m_tc    = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    int psv;
    int term;
    int nxt;
    bit tick;
    bit step;
    bit hold;
    bit arrive;
    bit to_done;
`ifdef PROG_COUNTER_PRESCALE_EN
    psv = int'(prescale);
`else
    psv = 0;
`endif
    tick = enable && (m_pre >= psv);
    step = (m_state == 1) && tick && !load;
    term = dir ? int'(limit) : 0;
    hold = (m_count == term) && saturate;
    if (m_count != term)
      nxt = dir ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
    else if (hold)
      nxt = m_count;
    else
      nxt = dir ? 0 : int'(limit);
    arrive  = step && !hold && (nxt == term);
    to_done = (m_state == 1) && !stop && arrive && oneshot;

    if (start || stop || load || to_done)
      m_pre = 0;
    else if (m_state == 1 && enable)
      m_pre = tick ? 0 : (m_pre + 1) % 16;

    if (stop)
      m_state = 0;
    else if (start && m_state != 1)
      m_state = 1;
    else if (to_done)
      m_state = 2;

    if (load)
      m_count = int'(load_val);
    else if (step)
      m_count = nxt;
    m_tc = arrive;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = '0; dir = 1'b1; oneshot = 1'b0; saturate = 1'b0; limit = 8'd5;
`ifdef PROG_COUNTER_PRESCALE_EN
    prescale = 4'd0;
`endif
    cyc(); cyc();
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b expected 0", tc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b expected 0", match); end
    rst_n = 1'b1;
    enable = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL reset_idle busy %b count %0d expected 0 0", busy, count); end
  endtask

  task automatic test_wrap_up();
    int e;
    limit = 8'd5; dir = 1'b1; saturate = 1'b0; oneshot = 1'b0; enable = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 8'd0) begin errors++; $display("FAIL wrap_start busy %b count %0d expected 1 0", busy, count); end
    for (int i = 1; i <= 18; i++) begin
      cyc();
      e = i % 6;
      checks++; if (count !== W'(e)) begin errors++; $display("FAIL wrap_count step %0d got %0d expected %0d", i, count, e); end
      checks++; if (tc !== (e == 5)) begin errors++; $display("FAIL wrap_tc step %0d got %b expected %b", i, tc, (e == 5)); end
      checks++; if (match !== (e == 5)) begin errors++; $display("FAIL wrap_match step %0d got %b expected %b", i, match, (e == 5)); end
    end
    enable = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL wrap_stop busy %b count %0d expected 0 0", busy, count); end
  endtask

  task automatic test_down_saturate();
    int e;
    int tcs = 0;
    dir = 1'b0; limit = 8'd3; saturate = 1'b1; load_val = 8'd2;
    load = 1'b1; cyc(); load = 1'b0;
    checks++; if (count !== 8'd2 || tc !== 1'b0) begin errors++; $display("FAIL sat_load count %0d tc %b expected 2 0", count, tc); end
    enable = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      e = (i == 0) ? 1 : 0;
      if (tc === 1'b1) tcs++;
      checks++; if (count !== W'(e)) begin errors++; $display("FAIL sat_count step %0d got %0d expected %0d", i, count, e); end
      checks++; if (tc !== (i == 1)) begin errors++; $display("FAIL sat_tc step %0d got %b expected %b", i, tc, (i == 1)); end
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL sat_match step %0d got %b expected 0", i, match); end
    end
    checks++; if (tcs != 1) begin errors++; $display("FAIL sat_tc_total got %0d expected 1", tcs); end
    enable = 1'b0; stop = 1'b1; cyc(); stop = 1'b0; saturate = 1'b0;
  endtask

  task automatic test_oneshot();
    dir = 1'b1; limit = 8'd4; oneshot = 1'b1; saturate = 1'b0; load_val = 8'd0;
    load = 1'b1; cyc(); load = 1'b0;
    enable = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (count !== W'(i)) begin errors++; $display("FAIL os_count step %0d got %0d expected %0d", i, count, i); end
      checks++; if (done !== (i == 4) || busy !== (i != 4)) begin errors++; $display("FAIL os_state step %0d done %b busy %b expected %b %b", i, done, busy, (i == 4), (i != 4)); end
      checks++; if (tc !== (i == 4)) begin errors++; $display("FAIL os_tc step %0d got %b expected %b", i, tc, (i == 4)); end
    end
    cyc();
    checks++; if (count !== 8'd4 || done !== 1'b1 || tc !== 1'b0) begin errors++; $display("FAIL os_hold count %0d done %b tc %b expected 4 1 0", count, done, tc); end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 8'd4) begin errors++; $display("FAIL os_restart busy %b count %0d expected 1 4", busy, count); end
    for (int j = 0; j <= 4; j++) begin
      cyc();
      checks++; if (count !== W'(j)) begin errors++; $display("FAIL os2_count step %0d got %0d expected %0d", j, count, j); end
      checks++; if (done !== (j == 4) || tc !== (j == 4)) begin errors++; $display("FAIL os2_done step %0d done %b tc %b expected %b", j, done, tc, (j == 4)); end
    end
    stop = 1'b1; cyc(); stop = 1'b0; oneshot = 1'b0; enable = 1'b0;
  endtask

  task automatic test_load_priority();
    int e;
    dir = 1'b1; limit = 8'h10; saturate = 1'b0; oneshot = 1'b0;
    load_val = 8'h0F; load = 1'b1; cyc(); load = 1'b0;
    enable = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    load_val = 8'h20; load = 1'b1; cyc(); load = 1'b0;
    checks++; if (count !== 8'h20 || tc !== 1'b0) begin errors++; $display("FAIL ld_prio count %h tc %b expected 20 0", count, tc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy got %b expected 1", busy); end
    for (int k = 1; k <= 230; k++) begin
      cyc();
      e = (32 + k) % MOD;
      checks++; if (count !== W'(e)) begin errors++; $display("FAIL ld_count step %0d got %h expected %h", k, count, e); end
      checks++; if (tc !== (e == 16)) begin errors++; $display("FAIL ld_tc step %0d got %b expected %b", k, tc, (e == 16)); end
    end
    enable = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    dir = 1'b1; limit = 8'd20; load_val = 8'd0;
    load = 1'b1; cyc(); load = 1'b0;
    enable = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    repeat (7) cyc();
    checks++; if (count !== 8'd7) begin errors++; $display("FAIL rst_pre count got %0d expected 7", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL rst_async count %0d busy %b tc %b expected 0 0 0", count, busy, tc); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL rst_after cyc %0d count %0d busy %b tc %b expected 0 0 0", i, count, busy, tc); end
    end
    enable = 1'b0;
  endtask

`ifdef PROG_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    prescale = 4'd2; dir = 1'b1; limit = 8'hFF; saturate = 1'b0; oneshot = 1'b0;
    load_val = 8'd0; load = 1'b1; cyc(); load = 1'b0;
    enable = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++; if (count !== W'(k / 3)) begin errors++; $display("FAIL ps_count cyc %0d got %0d expected %0d", k, count, k / 3); end
    end
    cyc();
    enable = 1'b0;
    repeat (4) cyc();
    enable = 1'b1;
    cyc();
    checks++; if (count !== 8'd3) begin errors++; $display("FAIL ps_freeze got %0d expected 3", count); end
    cyc();
    checks++; if (count !== 8'd4) begin errors++; $display("FAIL ps_resume got %0d expected 4", count); end
    enable = 1'b0; stop = 1'b1; cyc(); stop = 1'b0; prescale = 4'd0;
  endtask
`endif

  task automatic test_random();
    rst_n = 1'b0; enable = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 9) < 8);
      start  = ($urandom_range(0, 9) == 0);
      stop   = ($urandom_range(0, 24) == 0);
      load   = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) saturate = ~saturate;
      if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 47) == 0) limit = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      model_edge();
      cyc();
      checks++; if (count !== W'(m_count)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d expected %0d", i, count, m_count); end
      checks++; if (tc !== m_tc) begin errors++; $display("FAIL rnd_tc cyc %0d got %b expected %b", i, tc, m_tc); end
      checks++; if (busy !== (m_state == 1)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b expected %b", i, busy, (m_state == 1)); end
      checks++; if (done !== (m_state == 2)) begin errors++; $display("FAIL rnd_done cyc %0d got %b expected %b", i, done, (m_state == 2)); end
      checks++; if (match !== (m_count == int'(limit))) begin errors++; $display("FAIL rnd_match cyc %0d got %b expected %b", i, match, (m_count == int'(limit))); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_saturate();
    test_oneshot();
    test_load_priority();
    test_reset_mid_run();
`ifdef PROG_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
